// File: rtl/uart_rx_param.sv
// ============================================================================
// uart_rx_param
// ----------------------------------------------------------------------------
// Parametrised UART receiver. Deserialises one asynchronous serial line into
// DATA_BITS-wide words using an external oversampling tick, with input
// synchronisation, false-start rejection, framing/break detection and an
// optional parity check.
//
// Build option:
//   UART_RX_PARITY_EN  - when defined, one parity bit is expected between the
//                        data bits and the stop bit(s); parity_err and the
//                        parity term of break_det become live. When undefined
//                        the frame is start + DATA_BITS + STOP_BITS and
//                        parity_err stays 0.
//
// Parameters:
//   DATA_BITS  (5..9)         payload bits per frame
//   OVERSAMPLE (even, 8..32)  b_tick pulses per bit period
//   STOP_BITS  (1 or 2)       stop bits checked
//   PARITY_ODD (0/1)          0 = even parity, 1 = odd parity
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   rx         in   serial input, asynchronous to clk, idle high
//   b_tick     in   oversample tick, one clk wide, OVERSAMPLE per bit
//   rx_data    out  last received word, LSB = first bit on the line
//   rx_valid   out  one-cycle strobe when rx_data and the flags update
//   frame_err  out  a checked stop bit was sampled low in the last frame
//   parity_err out  parity mismatch in the last frame
//   break_det  out  last frame was all-zero data/parity with a low stop bit
//   dbg_state  out  current FSM state (IDLE=0, START=1, DATA=2, PARITY=3,
//                   STOP=4)
//
// Handshake: rx_valid is a pure strobe with no ready/backpressure. The
// consumer must take rx_data and the flags in the cycle rx_valid is high;
// afterwards they hold until the next frame commits.
// ============================================================================
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 b_tick,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic [2:0]           dbg_state
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] TICK_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          PO_BIT    = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [CW-1:0]          r_tick_cnt;
    logic [BW-1:0]          r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_ferr;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_break;

    logic                   w_rxs;
    logic                   w_ferr_final;
    logic                   w_par_zero;

    // Two-flop synchroniser; resets to the idle (high) line level so that
    // leaving reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // Framing error as it stands after folding in the current stop sample.
    assign w_ferr_final = r_ferr | ~w_rxs;

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;
    logic w_perr;

    // Total ones across data and parity must match the selected sense.
    assign w_perr     = ((^r_shift) ^ r_par_bit) != PO_BIT;
    assign w_par_zero = ~r_par_bit;
    assign parity_err = r_parity_err;
`else
    // PARITY_ODD has no meaning without a parity bit; the flag stays low.
    assign w_par_zero = 1'b1;
    assign parity_err = PO_BIT & 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_ferr       <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_break      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                // No b_tick needed here: a low line alone starts a frame, and a
                // tick coinciding with START entry is deliberately not counted.
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_ferr     <= 1'b0;
                        r_state    <= S_START;
                    end
                end

                S_START: begin
                    if (b_tick) begin
                        if (r_tick_cnt == TICK_MID) begin
                            r_tick_cnt <= '0;
                            // Line back high at mid start bit: glitch, drop it.
                            r_state    <= w_rxs ? S_IDLE : S_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + CW'(1);
                        end
                    end
                end

                S_DATA: begin
                    if (b_tick) begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {w_rxs, r_shift[DATA_BITS-1:1]};
                            if (r_bit_cnt == DATA_LAST) begin
                                r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                                r_state   <= S_PARITY;
`else
                                r_state   <= S_STOP;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BW'(1);
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + CW'(1);
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (b_tick) begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= '0;
                            r_par_bit  <= w_rxs;
                            r_state    <= S_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + CW'(1);
                        end
                    end
                end
`endif

                // The bit counter is reused to count stop bits. The last stop
                // sample commits the frame and drops straight to IDLE, which
                // is mid stop bit, so a following start edge is never missed.
                S_STOP: begin
                    if (b_tick) begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_tick_cnt <= '0;
                            if (r_bit_cnt == STOP_LAST) begin
                                r_bit_cnt    <= '0;
                                r_state      <= S_IDLE;
                                r_valid      <= 1'b1;
                                r_data       <= r_shift;
                                r_frame_err  <= w_ferr_final;
                                r_break      <= w_ferr_final & (r_shift == '0) & w_par_zero;
`ifdef UART_RX_PARITY_EN
                                r_parity_err <= w_perr;
`endif
                            end else begin
                                r_ferr    <= w_ferr_final;
                                r_bit_cnt <= r_bit_cnt + BW'(1);
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + CW'(1);
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign break_det = r_break;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  // Instance A: 8 data bits, x16, 1 stop, even parity.
  localparam int A_DB = 8;
  localparam int A_OS = 16;
  localparam int A_SB = 1;
  localparam int A_PO = 0;
  // Instance B: 7 data bits, x8, 2 stop, odd parity.
  localparam int B_DB = 7;
  localparam int B_OS = 8;
  localparam int B_SB = 2;
  localparam int B_PO = 1;

  localparam int W = 12;  // {break, parity_err, frame_err, data[8:0]}

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_tick = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  always #5 clk = ~clk;

  // Tick generator: one-cycle pulse with a random period of 2..4 clocks.
  initial begin
    forever begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      b_tick = 1'b1;
      @(negedge clk);
      b_tick = 1'b0;
    end
  end

  logic [A_DB-1:0] a_data;
  logic            a_valid, a_ferr, a_perr, a_brk;
  logic [2:0]      a_state;
  logic [B_DB-1:0] b_data;
  logic            b_valid, b_ferr, b_perr, b_brk;
  logic [2:0]      b_state;

  uart_rx_param #(.DATA_BITS(A_DB), .OVERSAMPLE(A_OS), .STOP_BITS(A_SB), .PARITY_ODD(A_PO)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .b_tick(b_tick),
    .rx_data(a_data), .rx_valid(a_valid), .frame_err(a_ferr),
    .parity_err(a_perr), .break_det(a_brk), .dbg_state(a_state)
  );

  uart_rx_param #(.DATA_BITS(B_DB), .OVERSAMPLE(B_OS), .STOP_BITS(B_SB), .PARITY_ODD(B_PO)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .b_tick(b_tick),
    .rx_data(b_data), .rx_valid(b_valid), .frame_err(b_ferr),
    .parity_err(b_perr), .break_det(b_brk), .dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic a_valid_prev = 1'b0;
  logic b_valid_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst && a_valid) begin
      check("a_valid_spacing", {31'd0, a_valid_prev}, 32'd0);
      if (exp_q_a.size() == 0) begin
        check("a_unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("a_frame", 32'({a_brk, a_perr, a_ferr, 9'(a_data)}), 32'(exp_q_a.pop_front()));
      end
    end
    a_valid_prev <= a_valid;
  end

  always @(negedge clk) begin
    if (!rst && b_valid) begin
      check("b_valid_spacing", {31'd0, b_valid_prev}, 32'd0);
      if (exp_q_b.size() == 0) begin
        check("b_unexpected_valid", 32'd1, 32'd0);
      end else begin
        check("b_frame", 32'({b_brk, b_perr, b_ferr, 9'(b_data)}), 32'(exp_q_b.pop_front()));
      end
    end
    b_valid_prev <= b_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (b_tick !== 1'b1) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx_a = v;
    else rx_b = v;
  endtask

  // Sends one frame and pushes the expected result. par_flip sends the wrong
  // parity bit; stop0/stop1 are the stop-bit line levels. A low final stop is
  // held just past its sampling point and the line then idles for a bit, so
  // the receiver's immediate re-arm sees a high line and rejects it.
  task automatic send_frame(input int which, input logic [8:0] d, input bit par_flip,
                            input bit stop0, input bit stop1, input int gap);
    int db, os, sb, po, extra;
    logic [8:0] dm;
    logic pbit, ferr, perr, brk, v;
    db = (which == 0) ? A_DB : B_DB;
    os = (which == 0) ? A_OS : B_OS;
    sb = (which == 0) ? A_SB : B_SB;
    po = (which == 0) ? A_PO : B_PO;
    dm = d & ((9'd1 << db) - 9'd1);
    // Correct parity bit makes the ones-count of data+parity even (po=0) or odd (po=1).
    pbit = 1'(($countones(dm) + po) % 2) ^ par_flip;
    perr = PAR_EN && ((($countones(dm) + int'(pbit)) % 2) != po);
    ferr = !stop0 || (sb == 2 && !stop1);
    brk  = ferr && (dm == 9'd0) && (!PAR_EN || !pbit);
    if (which == 0) exp_q_a.push_back({brk, perr, ferr, dm});
    else            exp_q_b.push_back({brk, perr, ferr, dm});

    extra = 0;
    set_rx(which, 1'b0);
    wait_ticks(os);
    for (int k = 0; k < db; k++) begin
      set_rx(which, dm[k]);
      wait_ticks(os);
    end
    if (PAR_EN) begin
      set_rx(which, pbit);
      wait_ticks(os);
    end
    for (int s = 0; s < sb; s++) begin
      v = (s == 0) ? stop0 : stop1;
      set_rx(which, v);
      if (s == sb - 1 && !v) begin
        wait_ticks(os / 2 + 3);
        set_rx(which, 1'b1);
        wait_ticks(os - os / 2 - 3);
        extra = os;
      end else begin
        wait_ticks(os);
      end
    end
    set_rx(which, 1'b1);
    wait_ticks(gap + extra);
  endtask

  task automatic glitch_a(input int len);
    set_rx(0, 1'b0);
    wait_ticks(len);
    set_rx(0, 1'b1);
    wait_ticks(2 * A_OS);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, vectors=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [8:0] d;
    bit flip, s0, s1;

    repeat (3) @(negedge clk);
    check("rst_a_data",  32'(a_data),  32'd0);
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_a_ferr",  32'(a_ferr),  32'd0);
    check("rst_a_perr",  32'(a_perr),  32'd0);
    check("rst_a_brk",   32'(a_brk),   32'd0);
    check("rst_a_state", 32'(a_state), 32'd0);
    check("rst_b_data",  32'(b_data),  32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    rst = 1'b0;
    wait_ticks(4);

    // Clean frame, glitch rejection, break frame, parity pair.
    send_frame(0, 9'hA5, 1'b0, 1'b1, 1'b1, 4);
    glitch_a(4);
    check("a_idle_after_glitch", 32'(a_state), 32'd0);
    send_frame(0, 9'h3C, 1'b0, 1'b1, 1'b1, 4);
    send_frame(0, 9'h00, 1'b0, 1'b0, 1'b1, 4);
    send_frame(0, 9'h81, 1'b0, 1'b1, 1'b1, 4);
    send_frame(0, 9'h03, PAR_EN, 1'b1, 1'b1, 4);
    send_frame(0, 9'h03, 1'b0, 1'b1, 1'b1, 4);

    // Back-to-back frames with no idle gap on both instances.
    send_frame(0, 9'h55, 1'b0, 1'b1, 1'b1, 0);
    send_frame(0, 9'hAA, 1'b0, 1'b1, 1'b1, 4);
    send_frame(1, 9'h7F, 1'b0, 1'b1, 1'b1, 0);
    send_frame(1, 9'h01, 1'b0, 1'b1, 1'b1, 4);
    send_frame(1, 9'h00, 1'b0, 1'b0, 1'b1, 4);

    // Reset during data bit 4 of 0xC3 on instance A.
    set_rx(0, 1'b0);
    wait_ticks(A_OS);
    d = 9'h0C3;
    for (int k = 0; k < 5; k++) begin
      set_rx(0, d[k]);
      wait_ticks((k == 4) ? A_OS / 2 : A_OS);
    end
    rst = 1'b1;
    #1;
    check("midrst_a_data",  32'(a_data),  32'd0);
    check("midrst_a_valid", 32'(a_valid), 32'd0);
    check("midrst_a_ferr",  32'(a_ferr),  32'd0);
    check("midrst_a_perr",  32'(a_perr),  32'd0);
    check("midrst_a_brk",   32'(a_brk),   32'd0);
    check("midrst_a_state", 32'(a_state), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    set_rx(0, 1'b1);
    wait_ticks(2 * A_OS);
    send_frame(0, 9'hC3, 1'b0, 1'b1, 1'b1, 4);

    // Randomized traffic on A, occasionally preceded by a start glitch.
    for (int i = 0; i < 16; i++) begin
      d = 9'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) d = 9'd0;
      flip = PAR_EN && ($urandom_range(0, 3) == 0);
      s0 = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 5) == 0) glitch_a($urandom_range(1, 5));
      send_frame(0, d, flip, s0, 1'b1, $urandom_range(0, 12));
    end

    // Randomized traffic on B; only the first of its two stop bits is corrupted.
    for (int i = 0; i < 16; i++) begin
      d = 9'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) d = 9'd0;
      flip = PAR_EN && ($urandom_range(0, 3) == 0);
      s0 = ($urandom_range(0, 4) != 0);
      s1 = 1'b1;
      send_frame(1, d, flip, s0, s1, $urandom_range(0, 12));
    end

    // Drain: every expected frame must have been presented.
    for (int c = 0; c < 2000 && (exp_q_a.size() != 0 || exp_q_b.size() != 0); c++)
      @(negedge clk);
    check("a_queue_drained", 32'(exp_q_a.size()), 32'd0);
    check("b_queue_drained", 32'(exp_q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
